// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: packed inputs, select, and the valid/ready
// pairs on both sides. The slave modport is the mux; master is its environment.
`timescale 1ns/1ps

interface mux_n_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] d;
  logic [SEL_W-1:0]        select;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  d,
    input  select,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out,
    output out_valid
  );

  modport master (
    output d,
    output select,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out,
    input  out_valid
  );
endinterface

// File: rtl/mux_n_pipe.sv
// NUM_IN:1 registered selector feeding a 2-entry skid buffer (main + skid).
// Optional sticky out-of-range select flag: define MUX_SEL_ERR_EN for sel_err.
`timescale 1ns/1ps

module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic         clk,
  input  logic         rst,
  mux_n_pipe_if.slave  bus
`ifdef MUX_SEL_ERR_EN
  ,
  output logic         sel_err
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic [WIDTH-1:0] in_word [NUM_IN];
  logic [WIDTH-1:0] cand_word;
  logic [WIDTH-1:0] sel_word;
  logic             sel_hit;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             pop;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign in_word[gi] = bus.d[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Out-of-range selects resolve to zero rather than aliasing onto a real input.
  always_comb begin
    cand_word = '0;
    sel_hit   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(bus.select) == k) begin
        cand_word = in_word[k];
        sel_hit   = 1'b1;
      end
    end
    sel_word = sel_hit ? cand_word : '0;
  end

  // Ready depends only on registered state, keeping out_ready off this path.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_BUSY;
          main_d  = sel_word;
        end
      end
      ST_BUSY: begin
        if (accept && pop) begin
          main_d = sel_word;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = sel_word;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = main_q;

`ifdef MUX_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q | (accept & ~sel_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule
